// File: rtl/control_cabina.sv
// Elevator cabin controller: moves one floor per T_PISO cycles and holds the door open for T_PUERTA cycles.
// Outputs are registered; a move in progress ignores commands until the next floor is reached.
module control_cabina #(
    parameter int T_PISO   = 16,
    parameter int T_PUERTA = 32,
    parameter int N_PISOS  = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] motor,
    input  logic       boton_abrir,
    output logic       cambio_piso,
    output logic       esperar,
    output logic [3:0] piso_actual,
    output logic [1:0] movimiento
);

    localparam int T_MAX = (T_PISO > T_PUERTA) ? T_PISO : T_PUERTA;
    localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CW-1:0] FIN_PISO   = CW'(T_PISO - 1);
    localparam logic [CW-1:0] FIN_PUERTA = CW'(T_PUERTA - 1);
    localparam logic [3:0]    PISO_TOP   = 4'(N_PISOS - 1);

    localparam logic [1:0] M_SUBIR = 2'b01;
    localparam logic [1:0] M_BAJAR = 2'b10;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        SUBIENDO = 2'd1,
        BAJANDO  = 2'd2,
        PUERTA   = 2'd3
    } estado_t;

    estado_t       r_estado;
    estado_t       w_estado_sig;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_sig;
    logic [3:0]    r_piso;
    logic [3:0]    w_piso_sig;
    logic [3:0]    w_piso_arriba;
    logic [3:0]    w_piso_abajo;
    logic          r_cambio;
    logic          w_cambio_sig;
    logic          r_esperar;
    logic          w_esperar_sig;
    logic [1:0]    r_mov;
    logic [1:0]    w_mov_sig;

    assign w_piso_arriba = r_piso + 4'd1;
    assign w_piso_abajo  = r_piso - 4'd1;

    always_comb begin
        w_estado_sig = r_estado;
        w_cnt_sig    = r_cnt + 1'b1;
        w_piso_sig   = r_piso;
        w_cambio_sig = 1'b0;

        case (r_estado)
            REPOSO: begin
                // A legal move always wins over the door button; illegal moves fall through.
                if (motor == M_SUBIR && r_piso < PISO_TOP) begin
                    w_estado_sig = SUBIENDO;
                    w_cnt_sig    = '0;
                end else if (motor == M_BAJAR && r_piso != 4'd0) begin
                    w_estado_sig = BAJANDO;
                    w_cnt_sig    = '0;
                end else if (boton_abrir) begin
                    w_estado_sig = PUERTA;
                    w_cnt_sig    = '0;
                end
            end

            SUBIENDO: begin
                if (r_cnt == FIN_PISO) begin
                    w_piso_sig   = w_piso_arriba;
                    w_cambio_sig = 1'b1;
                    w_cnt_sig    = '0;
                    if (!(motor == M_SUBIR && w_piso_arriba < PISO_TOP)) begin
                        w_estado_sig = PUERTA;
                    end
                end
            end

            BAJANDO: begin
                if (r_cnt == FIN_PISO) begin
                    w_piso_sig   = w_piso_abajo;
                    w_cambio_sig = 1'b1;
                    w_cnt_sig    = '0;
                    if (!(motor == M_BAJAR && w_piso_abajo != 4'd0)) begin
                        w_estado_sig = PUERTA;
                    end
                end
            end

            PUERTA: begin
                if (boton_abrir) begin
                    w_cnt_sig = '0;
                end else if (r_cnt == FIN_PUERTA) begin
                    w_estado_sig = REPOSO;
                    w_cnt_sig    = '0;
                end
            end

            default: begin
                w_estado_sig = REPOSO;
                w_cnt_sig    = '0;
            end
        endcase

        // Status outputs are derived from the next state so they register alongside it.
        w_esperar_sig = (w_estado_sig == PUERTA);
        case (w_estado_sig)
            SUBIENDO: w_mov_sig = 2'b01;
            BAJANDO:  w_mov_sig = 2'b10;
            default:  w_mov_sig = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_estado  <= REPOSO;
            r_cnt     <= '0;
            r_piso    <= 4'd0;
            r_cambio  <= 1'b0;
            r_esperar <= 1'b0;
            r_mov     <= 2'b00;
        end else begin
            r_estado  <= w_estado_sig;
            r_cnt     <= w_cnt_sig;
            r_piso    <= w_piso_sig;
            r_cambio  <= w_cambio_sig;
            r_esperar <= w_esperar_sig;
            r_mov     <= w_mov_sig;
        end
    end

    assign cambio_piso = r_cambio;
    assign esperar     = r_esperar;
    assign piso_actual = r_piso;
    assign movimiento  = r_mov;

endmodule

// File: tb/tb_control_cabina.sv
// Directed stimulus queues expected floor arrivals and door-open durations; a separate monitor
// pops them whenever the cabin pulses cambio_piso or closes its door.
module tb_control_cabina;

    localparam int T_PISO   = 16;
    localparam int T_PUERTA = 32;

    logic       clk;
    logic       reset_n;
    logic [1:0] motor;
    logic       boton_abrir;
    logic       cambio_piso;
    logic       esperar;
    logic [3:0] piso_actual;
    logic [1:0] movimiento;

    typedef struct {
        int piso;
        int cyc;
        int mov;
    } pulso_t;

    pulso_t q_pulso[$];
    int     q_puerta[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     piso_esp = 0;

    control_cabina #(
        .T_PISO(T_PISO),
        .T_PUERTA(T_PUERTA),
        .N_PISOS(10)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .motor(motor),
        .boton_abrir(boton_abrir),
        .cambio_piso(cambio_piso),
        .esperar(esperar),
        .piso_actual(piso_actual),
        .movimiento(movimiento)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Moves nf floors in direction dir, dropping motor to 00 partway through the last leg.
    task automatic mover(input logic [1:0] dir, input int nf, input logic btn);
        int n;
        int paso;
        int t1;
        pulso_t p;
        n    = cyc;
        paso = (dir == 2'b01) ? 1 : -1;
        for (int i = 1; i <= nf; i++) begin
            p.piso = piso_esp + paso * i;
            p.cyc  = n + 1 + T_PISO * i;
            p.mov  = (i < nf) ? int'(dir) : 0;
            q_pulso.push_back(p);
        end
        q_puerta.push_back(T_PUERTA);
        motor       = dir;
        boton_abrir = btn;
        tick();
        if (btn) begin
            chk("prioridad_movimiento", int'(movimiento), int'(dir));
            chk("prioridad_esperar", int'(esperar), 0);
        end
        boton_abrir = 1'b0;
        t1 = T_PISO * (nf - 1) + 5;
        repeat (t1 - 1) tick();
        motor = 2'b00;
        repeat (T_PISO * nf + 1 + T_PUERTA + 3 - t1) tick();
        piso_esp = piso_esp + paso * nf;
        chk("piso_destino", int'(piso_actual), piso_esp);
        chk("reposo_movimiento", int'(movimiento), 0);
        chk("reposo_esperar", int'(esperar), 0);
    endtask

    // Monitor: one queued arrival per cambio_piso cycle, one queued duration per door closing.
    initial begin
        int     run;
        pulso_t e;
        run = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                run = 0;
            end else begin
                if (cambio_piso) begin
                    if (q_pulso.size() == 0) begin
                        chk("pulso_inesperado", 1, 0);
                    end else begin
                        e = q_pulso.pop_front();
                        chk("pulso_piso", int'(piso_actual), e.piso);
                        chk("pulso_ciclo", cyc, e.cyc);
                        chk("pulso_movimiento", int'(movimiento), e.mov);
                    end
                end
                if (esperar) begin
                    run++;
                end else if (run > 0) begin
                    if (q_puerta.size() == 0) begin
                        chk("puerta_inesperada", run, 0);
                    end else begin
                        chk("puerta_duracion", run, q_puerta.pop_front());
                    end
                    run = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset_n     = 1'b1;
        motor       = 2'b00;
        boton_abrir = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_piso", int'(piso_actual), 0);
        chk("reset_esperar", int'(esperar), 0);
        chk("reset_movimiento", int'(movimiento), 0);
        chk("reset_cambio", int'(cambio_piso), 0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        mover(2'b01, 9, 1'b0);
        motor = 2'b01;
        repeat (20) tick();
        chk("tope_subir_piso", int'(piso_actual), 9);
        chk("tope_subir_movimiento", int'(movimiento), 0);
        motor = 2'b00;
        tick();

        mover(2'b10, 6, 1'b0);
        mover(2'b01, 1, 1'b0);
        mover(2'b10, 2, 1'b0);
        mover(2'b01, 1, 1'b1);

        // Door held open by a button pulse at counter 20; motor requests during the door are ignored.
        q_puerta.push_back(20 + 1 + T_PUERTA);
        boton_abrir = 1'b1;
        tick();
        boton_abrir = 1'b0;
        repeat (20) tick();
        boton_abrir = 1'b1;
        motor       = 2'b01;
        tick();
        boton_abrir = 1'b0;
        chk("puerta_ignora_motor", int'(movimiento), 0);
        chk("puerta_esperar", int'(esperar), 1);
        repeat (30) tick();
        motor = 2'b00;
        repeat (10) tick();
        chk("puerta_piso", int'(piso_actual), 3);

        mover(2'b01, 2, 1'b0);

        motor = 2'b10;
        tick();
        motor = 2'b00;
        repeat (7) tick();
        chk("bajando_movimiento", int'(movimiento), 2);
        reset_n = 1'b0;
        #1;
        chk("abort_piso", int'(piso_actual), 0);
        chk("abort_movimiento", int'(movimiento), 0);
        chk("abort_esperar", int'(esperar), 0);
        chk("abort_cambio", int'(cambio_piso), 0);
        repeat (3) tick();
        reset_n  = 1'b1;
        piso_esp = 0;
        tick();

        motor = 2'b10;
        repeat (20) tick();
        chk("suelo_bajar_movimiento", int'(movimiento), 0);
        chk("suelo_bajar_piso", int'(piso_actual), 0);
        motor = 2'b00;
        repeat (5) tick();
        chk("suelo_reposo_esperar", int'(esperar), 0);

        q_puerta.push_back(T_PUERTA);
        boton_abrir = 1'b1;
        tick();
        boton_abrir = 1'b0;
        chk("boton_abre_puerta", int'(esperar), 1);
        k = 0;
        while (esperar && k < 200) begin
            tick();
            k++;
        end
        repeat (3) tick();

        chk("pulsos_pendientes", q_pulso.size(), 0);
        chk("puertas_pendientes", q_puerta.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_cabina.md
CONTROL_CABINA -- requirements
Module: control_cabina

Interface
REQ-001 The block SHALL have parameter T_PISO, default 16: clock cycles to travel one floor.
REQ-002 The block SHALL have parameter T_PUERTA, default 32: clock cycles the door stays open.
REQ-003 The block SHALL have parameter N_PISOS, default 10: number of floors, numbered 0..N_PISOS-1.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port motor, input, 2 bits: motor command; 00 detener, 01 subir, 10 bajar, 11 treated as 00.
REQ-007 The block SHALL have port boton_abrir, input, 1 bit: open-door request, level-sampled each cycle.
REQ-008 The block SHALL have port cambio_piso, output, 1 bit: one-cycle pulse on arrival at a new floor.
REQ-009 The block SHALL have port esperar, output, 1 bit: high while the door is open.
REQ-010 The block SHALL have port piso_actual, output, 4 bits: current floor, 0..N_PISOS-1.
REQ-011 The block SHALL have port movimiento, output, 2 bits: 00 parado, 01 subiendo, 10 bajando.
REQ-012 All outputs SHALL be registered.

Function
REQ-013 The FSM SHALL have exactly four states: REPOSO, SUBIENDO, BAJANDO, PUERTA.
REQ-014 One cycle counter SHALL be cleared to 0 on every state entry and on every floor arrival, and SHALL increment by 1 each cycle otherwise.
REQ-015 REPOSO: motor=01 with piso_actual<N_PISOS-1 SHALL go to SUBIENDO; motor=10 with piso_actual>0 SHALL go to BAJANDO; otherwise boton_abrir=1 SHALL go to PUERTA; otherwise the FSM SHALL stay in REPOSO.
REQ-016 REPOSO priority: a legal move command SHALL win over boton_abrir.
REQ-017 An illegal move (subir at top floor, bajar at floor 0) SHALL be ignored, with no state change and no pulse.
REQ-018 SUBIENDO/BAJANDO: when counter==T_PISO-1, the next edge SHALL increment/decrement piso_actual by 1 and assert cambio_piso for exactly that one cycle.
REQ-019 At that same arrival edge, motor SHALL be sampled: same direction and still legal from the new floor -> stay moving with counter reset; any other value (00, 11, reverse, or now illegal) -> go to PUERTA.
REQ-020 While moving between floors, changes on motor and boton_abrir SHALL be ignored; the cabin never stops between floors.
REQ-021 PUERTA: boton_abrir=1 SHALL reset the counter to 0 (door held open); when counter==T_PUERTA-1 and boton_abrir=0, the next edge SHALL go to REPOSO.
REQ-022 PUERTA: motor commands SHALL be ignored.
REQ-023 esperar SHALL be 1 exactly while the state is PUERTA; with no reopen it SHALL be high for T_PUERTA consecutive cycles.
REQ-024 movimiento SHALL equal 01 in SUBIENDO, 10 in BAJANDO, and 00 otherwise.
REQ-025 Latency: a legal command accepted in REPOSO at edge k SHALL produce cambio_piso high in the cycle starting at edge k+T_PISO.
REQ-026 piso_actual SHALL never wrap; it SHALL saturate logically by REQ-017/REQ-019.
REQ-027 The arithmetic width of the counter SHALL be sufficient for max(T_PISO, T_PUERTA)-1.

Reset
REQ-028 reset_n=0 SHALL immediately, without waiting for a clock edge, force: state REPOSO, counter 0, piso_actual 0, cambio_piso 0, esperar 0, movimiento 00.
REQ-029 Reset asserted mid-travel or with the door open SHALL abort the operation with no pulse emitted.
REQ-030 The first active edge after reset_n rises SHALL evaluate REPOSO rules.

Verification
REQ-031 Reset, then motor=01 held: cambio_piso pulses every 16 cycles, piso_actual steps 1,2,...,9; at floor 9 state becomes PUERTA, esperar high 32 cycles, then REPOSO.
REQ-032 From floor 0, motor=10 or boton_abrir not asserted: no movement, movimiento=00, cambio_piso never asserted.
REQ-033 From floor 3 going up, motor changed to 00 at cycle 5 of travel: travel completes, piso_actual=4 at cycle 16 with one pulse, then PUERTA.
REQ-034 In PUERTA, boton_abrir pulsed at counter=20: esperar stays high for 20+1+32 cycles total; motor=01 during the door period is ignored.
REQ-035 reset_n dropped during BAJANDO from floor 5 (counter=7): outputs cleared asynchronously, piso_actual=0, no cambio_piso.
REQ-036 REPOSO with motor=01 and boton_abrir=1 in the same cycle at floor 2: the FSM goes to SUBIENDO, not PUERTA.
